// File: rtl/stack_pkg.sv
// Shared definitions for the return-address stack: default sizes,
// command encoding and the command decoder.
package stack_pkg;

   localparam int DEF_DEPTH = 8;
   localparam int DEF_AW    = 8;

   localparam logic [1:0] CMD_IDLE    = 2'd0;
   localparam logic [1:0] CMD_PUSH    = 2'd1;
   localparam logic [1:0] CMD_POP     = 2'd2;
   localparam logic [1:0] CMD_ILLEGAL = 2'd3;

   // Only the two exact legal patterns count as PUSH or POP.
   // Any other enabled pattern is illegal.
   function automatic logic [1:0] decode_cmd(input logic en,
                                             input logic sp_p,
                                             input logic sp_n,
                                             input logic rw);
      logic [1:0] c;
      if (!en)                     c = CMD_IDLE;
      else if (sp_p && !sp_n && rw)  c = CMD_PUSH;
      else if (!sp_p && sp_n && !rw) c = CMD_POP;
      else                         c = CMD_ILLEGAL;
      return c;
   endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x AW storage with one synchronous write port and one registered
// read port. The array itself is not reset. The read register is reset,
// so the popped address reads as zero after reset.
module stack_ram
   import stack_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [AW-1:0]            wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [AW-1:0]            rdata_o
);

   logic [AW-1:0] mem [DEPTH];
   logic [AW-1:0] rdata_q;

   // Write port: the entry is committed at the push edge.
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   // Read register: it only changes on a successful pop, and otherwise
   // holds the last popped value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/call_stack.sv
// Return-address stack between the control unit and the PC. It decodes
// the stack command lines, moves the entry count, and keeps the sticky
// error flags.
module call_stack
   import stack_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       Stack_EN,
   input  logic                       SP_p,
   input  logic                       SP_n,
   input  logic                       RW,
   input  logic [AW-1:0]              push_data,
   input  logic                       err_clr,
   output logic [AW-1:0]              pop_data,
   output logic                       pop_valid,
   output logic [$clog2(DEPTH):0]     sp,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       cmd_err
);

   localparam int ABITS = $clog2(DEPTH);
   localparam int SPW   = ABITS + 1;

   logic [1:0]       cmd;
   logic             do_push, do_pop;
   logic [SPW-1:0]   sp_q, sp_d;
   logic             pv_q;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             cerr_q, cerr_d;
   logic [ABITS-1:0] waddr, raddr;

   assign cmd   = decode_cmd(Stack_EN, SP_p, SP_n, RW);
   assign full  = (sp_q == SPW'(DEPTH));
   assign empty = (sp_q == '0);

   // The full and empty guards block the pointer move, so sp saturates
   // at both ends and never wraps.
   assign do_push = (cmd == CMD_PUSH) && !full;
   assign do_pop  = (cmd == CMD_POP)  && !empty;

   // The top entry sits at sp-1. The next free slot is sp. The low bits
   // are enough because the guards keep these addresses in range.
   assign waddr = sp_q[ABITS-1:0];
   assign raddr = sp_q[ABITS-1:0] - ABITS'(1);

   // Next-state pointer and sticky flags. An error event in the same
   // cycle as err_clr wins over the clear.
   always_comb begin
      sp_d   = sp_q;
      if (do_push)     sp_d = sp_q + SPW'(1);
      else if (do_pop) sp_d = sp_q - SPW'(1);
      ovf_d  = (ovf_q  && !err_clr) || ((cmd == CMD_PUSH) && full);
      unf_d  = (unf_q  && !err_clr) || ((cmd == CMD_POP)  && empty);
      cerr_d = (cerr_q && !err_clr) || (cmd == CMD_ILLEGAL);
   end

   // State registers. Reset is asynchronous and also clears pop_valid
   // immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q   <= '0;
         pv_q   <= 1'b0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         cerr_q <= 1'b0;
      end else begin
         sp_q   <= sp_d;
         pv_q   <= do_pop;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
         cerr_q <= cerr_d;
      end
   end

   stack_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (do_push),
      .waddr_i (waddr),
      .wdata_i (push_data),
      .re_i    (do_pop),
      .raddr_i (raddr),
      .rdata_o (pop_data)
   );

   assign sp        = sp_q;
   assign pop_valid = pv_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign cmd_err   = cerr_q;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack. It checks the DUT against a queue-based model of
// the stack on every falling edge, and adds literal checks that pin the
// model on the directed scenarios.
module tb_call_stack;

   localparam int DEPTH = 8;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          Stack_EN = 1'b0, SP_p = 1'b0, SP_n = 1'b0, RW = 1'b0;
   logic [AW-1:0] push_data = '0;
   logic          err_clr = 1'b0;
   logic [AW-1:0] pop_data;
   logic          pop_valid;
   logic [3:0]    sp;
   logic          full, empty, overflow, underflow, cmd_err;

   int checks = 0;
   int errors = 0;

   // Model state.
   int q[$];
   int m_pd  = 0;
   bit m_pv  = 0;
   bit m_ovf = 0, m_unf = 0, m_cerr = 0;

   call_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .Stack_EN(Stack_EN), .SP_p(SP_p),
      .SP_n(SP_n), .RW(RW), .push_data(push_data), .err_clr(err_clr),
      .pop_data(pop_data), .pop_valid(pop_valid), .sp(sp), .full(full),
      .empty(empty), .overflow(overflow), .underflow(underflow),
      .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pd = 0; m_pv = 0; m_ovf = 0; m_unf = 0; m_cerr = 0;
   endtask

   task automatic model_step(input logic en, input logic p, input logic n,
                             input logic rw, input logic [AW-1:0] d,
                             input logic clr);
      bit so = 0, su = 0, sc = 0;
      m_pv = 0;
      if (en) begin
         if (p && !n && rw) begin
            if (q.size() == DEPTH) so = 1;
            else q.push_back(int'(d));
         end else if (!p && n && !rw) begin
            if (q.size() == 0) su = 1;
            else begin m_pd = q.pop_back(); m_pv = 1; end
         end else sc = 1;
      end
      m_ovf  = (m_ovf  && !clr) || so;
      m_unf  = (m_unf  && !clr) || su;
      m_cerr = (m_cerr && !clr) || sc;
   endtask

   // Drive one command for one cycle and update the model with it.
   task automatic cyc(input logic en, input logic p, input logic n,
                      input logic rw, input logic [AW-1:0] d,
                      input logic clr);
      Stack_EN = en; SP_p = p; SP_n = n; RW = rw; push_data = d; err_clr = clr;
      @(posedge clk);
      model_step(en, p, n, rw, d, clr);
      @(negedge clk);
   endtask

   task automatic push(input logic [AW-1:0] d); cyc(1, 1, 0, 1, d, 0); endtask
   task automatic pop();                        cyc(1, 0, 1, 0, '0, 0); endtask
   task automatic idle();                       cyc(0, 0, 0, 0, '0, 0); endtask

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      chk("sp",        int'(sp),        q.size());
      chk("full",      int'(full),      int'(q.size() == DEPTH));
      chk("empty",     int'(empty),     int'(q.size() == 0));
      chk("pop_valid", int'(pop_valid), int'(m_pv));
      chk("pop_data",  int'(pop_data),  m_pd);
      chk("overflow",  int'(overflow),  int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_unf));
      chk("cmd_err",   int'(cmd_err),   int'(m_cerr));
   end

   initial begin
      logic [2:0] ill;
      int r;
      rst_n = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) idle();
      chk("lit_rst_sp", int'(sp), 0);
      chk("lit_rst_empty", int'(empty), 1);
      chk("lit_rst_flags", int'({full, overflow, underflow, cmd_err, pop_valid}), 0);

      // Pops must return the pushed values in LIFO order.
      push(8'h10); push(8'h20); push(8'h30);
      chk("lit_sp3", int'(sp), 3);
      pop(); chk("lit_pop30", int'(pop_data), 8'h30); chk("lit_pv30", int'(pop_valid), 1);
      pop(); chk("lit_pop20", int'(pop_data), 8'h20);
      pop(); chk("lit_pop10", int'(pop_data), 8'h10);
      idle(); chk("lit_pv_pulse", int'(pop_valid), 0);
      chk("lit_empty_end", int'(empty), 1);

      // Underflow, then clear it.
      pop();
      chk("lit_unf", int'(underflow), 1);
      chk("lit_unf_pv", int'(pop_valid), 0);
      chk("lit_unf_pd", int'(pop_data), 8'h10);
      cyc(0, 0, 0, 0, '0, 1);
      chk("lit_unf_clr", int'(underflow), 0);

      // Overflow.
      for (int i = 1; i <= 8; i++) push(AW'(i));
      push(8'hFF);
      chk("lit_ovf", int'(overflow), 1);
      chk("lit_ovf_sp", int'(sp), 8);
      chk("lit_ovf_full", int'(full), 1);
      pop(); chk("lit_ovf_pop", int'(pop_data), 8'h08);

      // Illegal command at sp=2.
      repeat (5) pop();
      chk("lit_sp2", int'(sp), 2);
      cyc(1, 1, 1, 0, 8'h55, 0);
      chk("lit_cerr", int'(cmd_err), 1);
      chk("lit_cerr_sp", int'(sp), 2);
      chk("lit_cerr_pv", int'(pop_valid), 0);
      // An error event in the same cycle as err_clr must keep the flag set.
      cyc(1, 0, 0, 1, '0, 1);
      chk("lit_set_wins", int'(cmd_err), 1);
      cyc(0, 0, 0, 0, '0, 1);

      // Drop reset between edges while pop_valid is high.
      push(8'hAA); pop();
      chk("lit_pre_rst_pv", int'(pop_valid), 1);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("lit_async_sp", int'(sp), 0);
      chk("lit_async_pv", int'(pop_valid), 0);
      chk("lit_async_empty", int'(empty), 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pop();
      chk("lit_post_rst_unf", int'(underflow), 1);

      // Random traffic. The push/pop bias alternates so that the stack
      // swings between full and empty.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 15);
         if (r < 2) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom_range(0, 15) == 0));
         else if (r < 14) begin
            if ((($urandom_range(0, 9) < 7) ^ ((i / 200) % 2 == 1)))
               cyc(1, 1, 0, 1, 8'($urandom), 1'($urandom_range(0, 15) == 0));
            else
               cyc(1, 0, 1, 0, 8'($urandom), 1'($urandom_range(0, 15) == 0));
         end else begin
            do ill = 3'($urandom); while (ill == 3'b101 || ill == 3'b010);
            cyc(1, ill[2], ill[1], ill[0], 8'($urandom), 1'($urandom_range(0, 15) == 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
